// File: rtl/legv8_pkg.sv
// legv8_pkg: LEGv8 instruction kinds, opcodes, immediate ranges and loader states
package legv8_pkg;
  typedef enum logic [3:0] {
    K_LDUR = 4'd0, K_STUR, K_ADD, K_SUB, K_AND, K_ORR, K_ADDI, K_CBZ, K_CBNZ
  } instr_kind_e;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} load_state_e;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ = 8'b10110101;
  localparam int LDST_IMM_MIN = -256;
  localparam int LDST_IMM_MAX = 255;
  localparam int ADDI_IMM_MIN = 0;
  localparam int ADDI_IMM_MAX = 4095;
  localparam int CB_IMM_MIN   = -262144;
  localparam int CB_IMM_MAX   = 262143;
  function automatic logic in_range(input logic [19:0] imm, input int lo, input int hi);
    int v;
    v = int'($signed(imm));
    return (v >= lo) && (v <= hi);
  endfunction
endpackage

// File: rtl/instr_packer.sv
// instr_packer: combinational packing of symbolic LEGv8 fields into a 32-bit word plus legality
module instr_packer
  import legv8_pkg::*;
(
  input  logic [3:0]  kind,
  input  logic [4:0]  rd,
  input  logic [4:0]  rn,
  input  logic [4:0]  rm,
  input  logic [19:0] imm,
  output logic [31:0] word,
  output logic        legal
);
  // pick the field layout for the kind and range-check its immediate
  always_comb begin
    word  = '0;
    legal = 1'b0;
    case (kind)
      K_LDUR: begin word = {OP_LDUR, imm[8:0], 2'b00, rn, rd}; legal = in_range(imm, LDST_IMM_MIN, LDST_IMM_MAX); end
      K_STUR: begin word = {OP_STUR, imm[8:0], 2'b00, rn, rd}; legal = in_range(imm, LDST_IMM_MIN, LDST_IMM_MAX); end
      K_ADD:  begin word = {OP_ADD, rm, 6'b0, rn, rd}; legal = 1'b1; end
      K_SUB:  begin word = {OP_SUB, rm, 6'b0, rn, rd}; legal = 1'b1; end
      K_AND:  begin word = {OP_AND, rm, 6'b0, rn, rd}; legal = 1'b1; end
      K_ORR:  begin word = {OP_ORR, rm, 6'b0, rn, rd}; legal = 1'b1; end
      K_ADDI: begin word = {OP_ADDI, imm[11:0], rn, rd}; legal = in_range(imm, ADDI_IMM_MIN, ADDI_IMM_MAX); end
      K_CBZ:  begin word = {OP_CBZ, imm[18:0], rd}; legal = in_range(imm, CB_IMM_MIN, CB_IMM_MAX); end
      K_CBNZ: begin word = {OP_CBNZ, imm[18:0], rd}; legal = in_range(imm, CB_IMM_MIN, CB_IMM_MAX); end
      default: begin word = '0; legal = 1'b0; end
    endcase
  end
endmodule

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: encodes a stream of symbolic instructions and writes them sequentially into instruction memory; ENC_CHECKSUM_EN adds an XOR signature output csum
module instr_encoder_loader
  import legv8_pkg::*;
#(
  parameter int ADDR_W    = 6,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_kind,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rn,
  input  logic [4:0]        in_rm,
  input  logic [19:0]       in_imm,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              done,
  output logic              err
`ifdef ENC_CHECKSUM_EN
  ,
  output logic [31:0]       csum
`endif
);
  load_state_e       state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d, waddr_q, waddr_d;
  logic [31:0]       wdata_q, wdata_d, word;
  logic [ADDR_W:0]   count_q, count_d;
  logic              ready_q, ready_d, we_q, we_d, done_q, done_d, err_q, err_d;
  logic              legal, accept;

  instr_packer u_packer (
    .kind  (in_kind),
    .rd    (in_rd),
    .rn    (in_rn),
    .rm    (in_rm),
    .imm   (in_imm),
    .word  (word),
    .legal (legal)
  );

  assign accept     = in_valid & ready_q;
  assign in_ready   = ready_q;
  assign imem_we    = we_q;
  assign imem_waddr = waddr_q;
  assign imem_wdata = wdata_q;
  assign count      = count_q;
  assign done       = done_q;
  assign err        = err_q;

  // next-state: start restarts and drops any same-cycle request; legal accepts produce one write, the top address or in_last ends the load
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    err_d   = err_q;
    count_d = we_q ? count_q + (ADDR_W+1)'(1) : count_q;
    if (start) begin
      state_d = S_LOAD;
      ptr_d   = ADDR_W'(BASE_ADDR);
      waddr_d = ADDR_W'(BASE_ADDR);
      count_d = '0;
      err_d   = 1'b0;
    end else if (accept) begin
      we_d  = legal;
      err_d = err_q | ~legal;
      if (legal) begin
        waddr_d = ptr_q;
        wdata_d = word;
        ptr_d   = ptr_q + ADDR_W'(1);
      end
      if (in_last | (legal & (&ptr_q))) state_d = S_DONE;
    end
    ready_d = state_d == S_LOAD;
    done_d  = state_d == S_DONE;
  end

  // state and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= ADDR_W'(BASE_ADDR);
      waddr_q <= ADDR_W'(BASE_ADDR);
      wdata_q <= '0;
      we_q    <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      ready_q <= ready_d;
      done_q  <= done_d;
      err_q   <= err_d;
      count_q <= count_d;
    end
  end

`ifdef ENC_CHECKSUM_EN
  logic [31:0] csum_q, csum_d;
  assign csum = csum_q;
  // fold each presented word into the signature on the edge that ends its write cycle
  always_comb csum_d = start ? '0 : we_q ? csum_q ^ wdata_q : csum_q;
  // signature register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) csum_q <= '0;
    else csum_q <= csum_d;
  end
`endif
endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader: scoreboard bench for the instruction encoder/loader (ENC_CHECKSUM_EN adds the signature test)
module tb_instr_encoder_loader;
  localparam int AW = 2;
  logic          clk = 1'b0, reset = 1'b1, start = 1'b0, in_valid = 1'b0, in_last = 1'b0;
  logic [3:0]    in_kind = '0;
  logic [4:0]    in_rd = '0, in_rn = '0, in_rm = '0;
  logic [19:0]   in_imm = '0;
  logic          in_ready, imem_we, done, err;
  logic [AW-1:0] imem_waddr;
  logic [31:0]   imem_wdata;
  logic [AW:0]   count;
`ifdef ENC_CHECKSUM_EN
  logic [31:0]   csum;
`endif

  typedef struct packed {logic [AW-1:0] a; logic [31:0] d;} exp_t;
  exp_t sb[$];
  int errors = 0, checks = 0;

  instr_encoder_loader #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_kind(in_kind), .in_rd(in_rd), .in_rn(in_rn), .in_rm(in_rm), .in_imm(in_imm),
    .in_last(in_last), .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .count(count), .done(done), .err(err)
`ifdef ENC_CHECKSUM_EN
    , .csum(csum)
`endif
  );

  always #5 clk = ~clk;

  // scoreboard: every presented write must match the oldest expected word
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%0d data=%h", imem_waddr, imem_wdata);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (imem_waddr !== e.a || imem_wdata !== e.d) begin
          errors++;
          $display("FAIL write got addr=%0d data=%h expected addr=%0d data=%h", imem_waddr, imem_wdata, e.a, e.d);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] rtype(input logic [10:0] op, input logic [4:0] rd, input logic [4:0] rn, input logic [4:0] rm);
    return {op, rm, 6'b0, rn, rd};
  endfunction

  task automatic send(input logic [3:0] k, input logic [4:0] rd, input logic [4:0] rn, input logic [4:0] rm,
                      input logic [19:0] imm, input logic last);
    int n = 0;
    in_kind = k; in_rd = rd; in_rn = rn; in_rm = rm; in_imm = imm; in_last = last; in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n == 20) begin
      errors++;
      $display("FAIL send_timeout in_ready=%b required 1", in_ready);
    end else begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drain(input string name);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain pending=%0d required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, imem_we, done, err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got=%b required 0000", {in_ready, imem_we, done, err});
    end
    checks++;
    if (count !== '0 || imem_waddr !== '0 || imem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_regs count=%0d waddr=%0d wdata=%h required 0 0 0", count, imem_waddr, imem_wdata);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_ready got=%b required 0", in_ready);
    end
  endtask

  task automatic test_add();
    do_start();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL start_ready got=%b required 1", in_ready);
    end
    sb.push_back('{a: 2'd0, d: 32'h8B030041});
    send(4'd2, 5'd1, 5'd2, 5'd3, 20'd0, 1'b1);
    checks++;
    if (imem_we !== 1'b1 || done !== 1'b1) begin
      errors++;
      $display("FAIL add_write_cycle we=%b done=%b required 1 1", imem_we, done);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b1 || count !== 3'd1 || imem_we !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL add_after done=%b count=%0d we=%b ready=%b required 1 1 0 0", done, count, imem_we, in_ready);
    end
    drain("add");
  endtask

  task automatic test_back_to_back();
    time t0;
    do_start();
    sb.push_back('{a: 2'd0, d: 32'hF85F80C5});
    sb.push_back('{a: 2'd1, d: 32'hF80080C7});
    send(4'd0, 5'd5, 5'd6, 5'd0, -20'sd8, 1'b0);
    t0 = $time;
    send(4'd1, 5'd7, 5'd6, 5'd0, 20'd8, 1'b1);
    checks++;
    if ($time - t0 != 10 || imem_we !== 1'b1) begin
      errors++;
      $display("FAIL b2b_spacing got=%0t we=%b required 10 1", $time - t0, imem_we);
    end
    @(posedge clk); #1;
    checks++;
    if (count !== 3'd2 || done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_count count=%0d done=%b required 2 1", count, done);
    end
    drain("b2b");
  endtask

  task automatic test_reject();
    do_start();
    send(4'd6, 5'd1, 5'd1, 5'd0, 20'd4096, 1'b0);
    checks++;
    if (imem_we !== 1'b0 || err !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reject_addi we=%b err=%b ready=%b required 0 1 1", imem_we, err, in_ready);
    end
    sb.push_back('{a: 2'd0, d: 32'hB4FFFFE9});
    send(4'd7, 5'd9, 5'd0, 5'd0, 20'hFFFFF, 1'b1);
    @(posedge clk); #1;
    checks++;
    if (count !== 3'd1 || err !== 1'b1 || done !== 1'b1) begin
      errors++;
      $display("FAIL reject_after count=%0d err=%b done=%b required 1 1 1", count, err, done);
    end
    do_start();
    send(4'd15, 5'd0, 5'd0, 5'd0, 20'd0, 1'b1);
    checks++;
    if (imem_we !== 1'b0 || err !== 1'b1 || done !== 1'b1 || count !== 3'd0) begin
      errors++;
      $display("FAIL reject_last we=%b err=%b done=%b count=%0d required 0 1 1 0", imem_we, err, done, count);
    end
    drain("reject");
  endtask

  task automatic test_fill();
    do_start();
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{a: AW'(i), d: rtype(11'b10101010000, 5'(i), 5'(i + 1), 5'(i + 2))});
      send(4'd5, 5'(i), 5'(i + 1), 5'(i + 2), 20'd0, 1'b0);
    end
    checks++;
    if (in_ready !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL fill_top ready=%b done=%b required 0 1", in_ready, done);
    end
    in_kind = 4'd5; in_rd = 5'd9; in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++;
    if (count !== 3'd4 || done !== 1'b1 || imem_waddr !== 2'd3) begin
      errors++;
      $display("FAIL fill_end count=%0d done=%b waddr=%0d required 4 1 3", count, done, imem_waddr);
    end
    drain("fill");
  endtask

  task automatic test_restart();
    do_start();
    sb.push_back('{a: 2'd0, d: 32'h8B030041});
    send(4'd2, 5'd1, 5'd2, 5'd3, 20'd0, 1'b0);
    send(4'd15, 5'd0, 5'd0, 5'd0, 20'd0, 1'b0);
    in_kind = 4'd4; in_rd = 5'd4; in_rn = 5'd4; in_rm = 5'd4; in_valid = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0;
    checks++;
    if (imem_we !== 1'b0 || count !== 3'd0 || err !== 1'b0 || done !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL restart_clear we=%b count=%0d err=%b done=%b ready=%b required 0 0 0 0 1", imem_we, count, err, done, in_ready);
    end
    sb.push_back('{a: 2'd0, d: 32'hCB030041});
    send(4'd3, 5'd1, 5'd2, 5'd3, 20'd0, 1'b1);
    drain("restart");
  endtask

`ifdef ENC_CHECKSUM_EN
  task automatic test_checksum();
    do_start();
    checks++;
    if (csum !== 32'h0) begin
      errors++;
      $display("FAIL csum_clear got=%h required 0", csum);
    end
    sb.push_back('{a: 2'd0, d: 32'h8B030041});
    sb.push_back('{a: 2'd1, d: 32'hCB030041});
    send(4'd2, 5'd1, 5'd2, 5'd3, 20'd0, 1'b0);
    send(4'd3, 5'd1, 5'd2, 5'd3, 20'd0, 1'b1);
    @(posedge clk); #1;
    checks++;
    if (csum !== 32'h40000000) begin
      errors++;
      $display("FAIL csum got=%h required 40000000", csum);
    end
    drain("csum");
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_reject();
    test_fill();
    test_restart();
`ifdef ENC_CHECKSUM_EN
    test_checksum();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Encoder counterpart of the main control decoder.
- Accepts symbolic LEGv8 instructions (kind + register fields + immediate) over a valid/ready stream and packs them into 32-bit machine words.
- Writes the words sequentially into instruction memory via its write port.
- Used by the testbench/boot path to load programs that the datapath then fetches and decodes.

Parameters:
- ADDR_W, 6, instruction-memory word-address width (depth 2^ADDR_W).
- BASE_ADDR, 0, first word address written after start.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-high reset.
- start  in  1  pulse: clear address/count/error and enter LOAD.
- in_valid  in  1  instruction request valid.
- in_ready  out  1  loader can accept a request.
- in_kind  in  4  0 LDUR, 1 STUR, 2 ADD, 3 SUB, 4 AND, 5 ORR, 6 ADDI, 7 CBZ, 8 CBNZ; others illegal.
- in_rd  in  5  Rd/Rt.
- in_rn  in  5  Rn.
- in_rm  in  5  Rm.
- in_imm  in  20  signed immediate/offset (word offset for CBZ/CBNZ).
- in_last  in  1  marks final instruction of the program.
- imem_we  out  1  write strobe.
- imem_waddr  out  ADDR_W  word address.
- imem_wdata  out  32  encoded word.
- count  out  ADDR_W+1  words written since start.
- done  out  1  program loaded.
- err  out  1  sticky: at least one request rejected.

Behaviour:
- Reset: state IDLE; in_ready, imem_we, done, err = 0; count = 0; imem_waddr = BASE_ADDR; imem_wdata = 0.
- FSM: IDLE -(start)-> LOAD -(accept with in_last, or write to address 2^ADDR_W-1)-> DONE -(start)-> LOAD. start in any state restarts LOAD and clears count/err/done; a write already in flight that cycle is cancelled.
- in_ready = 1 only in LOAD. Accept = in_valid & in_ready.
- Latency: request accepted at edge N → imem_we = 1 for exactly the cycle after N, carrying imem_wdata/imem_waddr. One word per cycle sustained. No back-pressure from memory.
- Encoding (bits [31:0]):
  - LDUR 11111000010 / STUR 11111000000: imm9[20:12], 00[11:10], Rn[9:5], Rt[4:0].
  - ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000: Rm[20:16], shamt 0[15:10], Rn, Rd.
  - ADDI 1001000100[31:22]: imm12[21:10], Rn, Rd.
  - CBZ 10110100 / CBNZ 10110101 [31:24]: imm19[23:5], Rt[4:0].
- Range rules: LDUR/STUR −256..255; ADDI 0..4095; CBZ/CBNZ −262144..262143.
- Out-of-range immediate or illegal kind: request is still accepted (handshake completes), nothing is written, address/count not advanced, err set. in_last on a rejected request still ends the load.
- After each write: address += 1, count += 1. If the write targets 2^ADDR_W−1, go to DONE with in_ready low; the address never wraps.
- done = 1 in DONE, and from the cycle the last write is presented.

Optional Feature:
- Macro ENC_CHECKSUM_EN.
- When defined: extra output csum[31:0], cleared on reset and start, XOR-accumulated with every written word, updated the cycle after the write; lets the bench compare against the expected program signature.
- When undefined: port and logic absent.

Decomposition:
- Package legv8_pkg:
  - instr_kind_e enum;
  - 11/10/8-bit opcode constants for every kind, shared with the main decoder;
  - immediate range constants.
- Sub-module instr_packer: purely combinational fields → {word, legal}. The top holds the FSM, output register, and counters.

Test Plan:
- Reset, start, one ADD rd=1 rn=2 rm=3 with in_last → imem_we one cycle later, waddr 0, wdata 0x8B030041; done next cycle; count 1.
- LDUR rt=5 rn=6 imm=−8, STUR rt=7 rn=6 imm=8, back-to-back → 0xF85F80C5 at addr 0, 0xF80080C7 at addr 1, consecutive cycles.
- ADDI imm=4096, then CBZ rt=9 imm=−1 → first rejected (err=1, no write); CBZ written at addr 0 as 0xB4FFFFE9.
- ADDR_W=2, stream 5 ORR → 4 writes (addr 0–3), in_ready low after the 4th, done=1, count 4.
- start asserted mid-stream → count/err cleared, next write at BASE_ADDR; no stale write.
- With ENC_CHECKSUM_EN: ADD and SUB words from the first cases → csum equals their XOR.
